// File: rtl/jmp_seq_ctrl_pkg.sv
// Shared definitions for jump resolution: condition codes and sequencer state encodings.
// Imported by decode as well as by the sequencer itself.
package jmp_seq_ctrl_pkg;

    localparam logic [3:0] COND_ZERO       = 4'd0;
    localparam logic [3:0] COND_NOTZERO    = 4'd1;
    localparam logic [3:0] COND_EQUAL      = 4'd2;
    localparam logic [3:0] COND_NOTEQUAL   = 4'd3;
    localparam logic [3:0] COND_GREATER    = 4'd4;
    localparam logic [3:0] COND_LESS       = 4'd5;
    localparam logic [3:0] COND_GREATEQUAL = 4'd6;
    localparam logic [3:0] COND_LESSEQUAL  = 4'd7;
    localparam logic [3:0] COND_CARRY      = 4'd8;
    localparam logic [3:0] COND_NOTCARRY   = 4'd9;
    localparam logic [3:0] COND_UNCOND     = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FLAGS = 2'd1,
        ST_REDIRECT   = 2'd2,
        ST_FLUSH      = 2'd3
    } jmp_state_e;

endpackage

// File: rtl/jmp_seq_ctrl_if.sv
// Jump request / redirect bundle between execute, the flag register, fetch and the sequencer.
// master = execute/flags side driving the request, slave = the sequencer.
interface jmp_seq_ctrl_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
);
    logic              jmp_req;
    logic [3:0]        jmp_op;
    logic [PC_W-1:0]   jmp_target;
    logic              flags_busy;
    logic              carry;
    logic              sign;
    logic              zero;
    logic              stall_in;

    logic              jmp_ack;
    logic              pc_load;
    logic [PC_W-1:0]   pc_target;
    logic              flush;
    logic              hold_fetch;
    logic              busy;
    logic [CNT_W-1:0]  taken_cnt;
    logic [CNT_W-1:0]  not_taken_cnt;

    modport master (
        output jmp_req, jmp_op, jmp_target, flags_busy, carry, sign, zero, stall_in,
        input  jmp_ack, pc_load, pc_target, flush, hold_fetch, busy, taken_cnt, not_taken_cnt
    );

    modport slave (
        input  jmp_req, jmp_op, jmp_target, flags_busy, carry, sign, zero, stall_in,
        output jmp_ack, pc_load, pc_target, flush, hold_fetch, busy, taken_cnt, not_taken_cnt
    );
endinterface

// File: rtl/jmp_seq_ctrl_cond_eval.sv
// Purely combinational branch condition decode from the 4-bit op and the ALU flags.
// Codes above UNCONDITIONAL are reserved and never taken.
module jmp_seq_ctrl_cond_eval
    import jmp_seq_ctrl_pkg::*;
(
    input  logic [3:0] op,
    input  logic       carry,
    input  logic       sign,
    input  logic       zero,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (op)
            COND_ZERO,
            COND_EQUAL:      taken = zero;
            COND_NOTZERO,
            COND_NOTEQUAL:   taken = ~zero;
            COND_GREATER:    taken = ~sign & ~zero;
            COND_LESS:       taken = sign & ~zero;
            COND_GREATEQUAL: taken = ~sign | zero;
            COND_LESSEQUAL:  taken = sign | zero;
            COND_CARRY:      taken = carry;
            COND_NOTCARRY:   taken = ~carry;
            COND_UNCOND:     taken = 1'b1;
            default:         taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/jmp_seq_ctrl.sv
// Branch resolution sequencer: accepts one jump, waits for final flags, redirects fetch
// and flushes the wrong-path stages, then acknowledges. Keeps taken/not-taken statistics.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// IDLE        | no jump in flight; accept and resolve immediately if flags final
// WAIT_FLAGS  | jump latched, older flag writer in flight; fetch held
// REDIRECT    | one cycle: pc_load of latched target, flush starts
// FLUSH       | remaining flush cycles; ack on the last one
module jmp_seq_ctrl
    import jmp_seq_ctrl_pkg::*;
#(
    parameter int PC_W         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    jmp_seq_ctrl_if.slave   bus
);

    localparam int FC_LOAD = (FLUSH_CYCLES >= 2) ? FLUSH_CYCLES - 2 : 0;
    localparam int FC_W    = (FC_LOAD > 1) ? $clog2(FC_LOAD + 1) : 1;

    jmp_state_e        state_q, state_d;
    logic [3:0]        op_q;
    logic [PC_W-1:0]   target_q;
    logic [FC_W-1:0]   flush_cnt_q;
    logic              ack_nt_q;
    logic              nt_d;
    logic [CNT_W-1:0]  taken_cnt_q;
    logic [CNT_W-1:0]  nt_cnt_q;

    logic              accept;
    logic              jmp_ack;
    logic [3:0]        op_eval;
    logic              taken;

    // In IDLE the op has not been latched yet, so resolve on the live request.
    assign op_eval = (state_q == ST_IDLE) ? bus.jmp_op : op_q;

    jmp_seq_ctrl_cond_eval u_cond_eval (
        .op    (op_eval),
        .carry (bus.carry),
        .sign  (bus.sign),
        .zero  (bus.zero),
        .taken (taken)
    );

    assign accept = (state_q == ST_IDLE) & bus.jmp_req & ~bus.stall_in & ~jmp_ack;

    always_comb begin
        state_d = state_q;
        nt_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if ((bus.jmp_op == COND_UNCOND) || !bus.flags_busy) begin
                        if (taken) state_d = ST_REDIRECT;
                        else       nt_d    = 1'b1;
                    end else begin
                        state_d = ST_WAIT_FLAGS;
                    end
                end
            end
            ST_WAIT_FLAGS: begin
                if (!bus.flags_busy) begin
                    if (taken) begin
                        state_d = ST_REDIRECT;
                    end else begin
                        state_d = ST_IDLE;
                        nt_d    = 1'b1;
                    end
                end
            end
            ST_REDIRECT: state_d = (FLUSH_CYCLES == 1) ? ST_IDLE : ST_FLUSH;
            ST_FLUSH:    if (flush_cnt_q == '0) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            target_q    <= '0;
            flush_cnt_q <= '0;
            ack_nt_q    <= 1'b0;
            taken_cnt_q <= '0;
            nt_cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ack_nt_q <= nt_d;
            if (accept) begin
                op_q     <= bus.jmp_op;
                target_q <= bus.jmp_target;
            end
            if (state_q == ST_REDIRECT)
                flush_cnt_q <= FC_W'(FC_LOAD);
            else if ((state_q == ST_FLUSH) && (flush_cnt_q != '0))
                flush_cnt_q <= flush_cnt_q - 1'b1;
            if ((state_q == ST_REDIRECT) && (taken_cnt_q != '1))
                taken_cnt_q <= taken_cnt_q + 1'b1;
            if (nt_d && (nt_cnt_q != '1))
                nt_cnt_q <= nt_cnt_q + 1'b1;
        end
    end

    // Taken jumps ack on the last flush cycle; not-taken jumps ack from the registered pulse.
    assign jmp_ack = ack_nt_q
                   | ((state_q == ST_FLUSH) && (flush_cnt_q == '0))
                   | ((state_q == ST_REDIRECT) && (FLUSH_CYCLES == 1));

    assign bus.jmp_ack       = jmp_ack;
    assign bus.pc_load       = (state_q == ST_REDIRECT);
    assign bus.pc_target     = target_q;
    assign bus.flush         = (state_q == ST_REDIRECT) || (state_q == ST_FLUSH);
    assign bus.hold_fetch    = (state_q == ST_WAIT_FLAGS);
    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.taken_cnt     = taken_cnt_q;
    assign bus.not_taken_cnt = nt_cnt_q;

endmodule

// File: tb/tb_jmp_seq_ctrl.sv
// Scoreboard bench for jmp_seq_ctrl: default instance checked per jump by a monitor,
// second instance (3 flush cycles, 2-bit counters) for saturation and mid-flush reset.
module tb_jmp_seq_ctrl;

    localparam int FC_A = 2;
    localparam int FC_B = 3;

    logic clk;
    logic rst_a, rst_b;
    int   cyc;
    int   n_cmp, n_err;

    jmp_seq_ctrl_if #(.PC_W(32), .CNT_W(16)) ifa ();
    jmp_seq_ctrl_if #(.PC_W(32), .CNT_W(2))  ifb ();

    jmp_seq_ctrl #(.PC_W(32), .FLUSH_CYCLES(FC_A), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_a), .bus(ifa)
    );
    jmp_seq_ctrl #(.PC_W(32), .FLUSH_CYCLES(FC_B), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_b), .bus(ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    typedef struct {
        logic        taken;
        logic [31:0] tgt;
        int          start;
        int          k;
    } exp_t;

    exp_t sb[$];
    int   exp_tk, exp_nt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic model_taken(input logic [3:0] op, input logic c, s, z);
        case (op)
            4'd0, 4'd2: return z;
            4'd1, 4'd3: return !z;
            4'd4:       return !s && !z;
            4'd5:       return s && !z;
            4'd6:       return !s || z;
            4'd7:       return s || z;
            4'd8:       return c;
            4'd9:       return !c;
            4'd10:      return 1'b1;
            default:    return 1'b0;
        endcase
    endfunction

    // Monitor for instance A: accumulate per-jump activity, settle against scoreboard on ack.
    int hold_n, flush_n, pcl_n, pcl_cyc;
    logic [31:0] pcl_tgt;
    always @(negedge clk) begin
        if (!rst_a) begin
            hold_n = 0; flush_n = 0; pcl_n = 0;
        end else begin
            if (ifa.hold_fetch) hold_n++;
            if (ifa.flush)      flush_n++;
            if (ifa.pc_load) begin
                pcl_n++;
                pcl_cyc = cyc;
                pcl_tgt = ifa.pc_target;
            end
            if (ifa.jmp_ack) begin
                if (sb.size() == 0) begin
                    chk("spurious_ack", 64'(1), 64'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("ack_latency", 64'(cyc - e.start), 64'(e.taken ? e.k + FC_A : e.k + 1));
                    chk("pc_load_count", 64'(pcl_n), 64'(e.taken));
                    if (e.taken) begin
                        chk("pc_load_latency", 64'(pcl_cyc - e.start), 64'(e.k + 1));
                        chk("pc_target", 64'(pcl_tgt), 64'(e.tgt));
                    end
                    chk("flush_cycles", 64'(flush_n), 64'(e.taken ? FC_A : 0));
                    chk("hold_cycles", 64'(hold_n), 64'(e.k));
                end
                hold_n = 0; flush_n = 0; pcl_n = 0;
            end
        end
    end

    // One jump on instance A: st stall cycles before acceptance, k cycles of flags_busy after.
    task automatic drive_a(input logic [3:0] op, input logic [31:0] tgt,
                           input logic c, s, z, input int k, input int st);
        exp_t e;
        int   t;
        logic tk;
        ifa.jmp_req    = 1'b1;
        ifa.jmp_op     = op;
        ifa.jmp_target = tgt;
        ifa.stall_in   = (st > 0);
        ifa.flags_busy = (k > 0);
        {ifa.carry, ifa.sign, ifa.zero} = (k > 0) ? ~{c, s, z} : {c, s, z};
        for (int i = 0; i < st; i++) begin
            @(negedge clk);
            chk("stall_blocks_accept", 64'(ifa.busy | ifa.jmp_ack), 64'(0));
        end
        ifa.stall_in = 1'b0;
        tk = model_taken(op, c, s, z);
        e.taken = tk;
        e.tgt   = tgt;
        e.start = cyc;
        e.k     = (op == 4'd10) ? 0 : k;
        sb.push_back(e);
        if (tk) exp_tk++; else exp_nt++;
        @(negedge clk);
        // Request fields change after acceptance; the latched copies must be used.
        ifa.jmp_op     = ~op;
        ifa.jmp_target = ~tgt;
        if (k > 0) begin
            repeat (k - 1) @(negedge clk);
            ifa.flags_busy = 1'b0;
            {ifa.carry, ifa.sign, ifa.zero} = {c, s, z};
        end
        t = 0;
        while (!ifa.jmp_ack && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) chk("ack_timeout", 64'(0), 64'(1));
        // Request stays high across the ack edge; it must not be accepted again.
        @(negedge clk);
        chk("no_reaccept", 64'(ifa.busy), 64'(0));
        ifa.jmp_req = 1'b0;
        chk("taken_cnt", 64'(ifa.taken_cnt), 64'(exp_tk));
        chk("not_taken_cnt", 64'(ifa.not_taken_cnt), 64'(exp_nt));
    endtask

    task automatic jump_b(input logic [3:0] op, output int lat);
        int t;
        ifb.jmp_req = 1'b1;
        ifb.jmp_op  = op;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!ifb.jmp_ack && t < 40);
        if (t >= 40) chk("b_ack_timeout", 64'(0), 64'(1));
        lat = t;
        @(negedge clk);
        ifb.jmp_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int lat;
        int acks;
        n_cmp = 0; n_err = 0; cyc = 0; exp_tk = 0; exp_nt = 0;
        rst_a = 1'b0; rst_b = 1'b0;
        ifa.jmp_req = 0; ifa.jmp_op = 0; ifa.jmp_target = 0; ifa.flags_busy = 0;
        ifa.carry = 0; ifa.sign = 0; ifa.zero = 0; ifa.stall_in = 0;
        ifb.jmp_req = 0; ifb.jmp_op = 0; ifb.jmp_target = 0; ifb.flags_busy = 0;
        ifb.carry = 0; ifb.sign = 0; ifb.zero = 0; ifb.stall_in = 0;

        repeat (2) @(negedge clk);
        ifa.jmp_req = 1'b1; ifa.jmp_op = 4'd10;
        @(negedge clk);
        chk("rst_busy", 64'(ifa.busy), 64'(0));
        chk("rst_pc_load", 64'(ifa.pc_load), 64'(0));
        chk("rst_ack", 64'(ifa.jmp_ack), 64'(0));
        chk("rst_flush", 64'(ifa.flush), 64'(0));
        chk("rst_hold", 64'(ifa.hold_fetch), 64'(0));
        chk("rst_target", 64'(ifa.pc_target), 64'(0));
        chk("rst_taken_cnt", 64'(ifa.taken_cnt), 64'(0));
        chk("rst_nt_cnt", 64'(ifa.not_taken_cnt), 64'(0));
        ifa.jmp_req = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1;
        @(negedge clk);

        drive_a(4'd10, 32'h0000_0040, 1'b0, 1'b0, 1'b0, 0, 0);
        drive_a(4'd2,  32'h0000_0080, 1'b0, 1'b0, 1'b0, 0, 0);
        drive_a(4'd5,  32'h0000_0100, 1'b0, 1'b1, 1'b0, 3, 0);
        drive_a(4'd0,  32'h0000_0200, 1'b0, 1'b0, 1'b1, 0, 3);
        drive_a(4'd10, 32'h0000_0300, 1'b0, 1'b0, 1'b0, 2, 0);

        for (int op = 0; op < 16; op++) begin
            for (int f = 0; f < 8; f++) begin
                drive_a(4'(op), 32'h1000 + 32'(op * 16 + f * 4),
                        f[2], f[1], f[0], (op + f) % 3, (f == 5) ? 2 : 0);
            end
        end
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));

        // Instance B: 3 flush cycles, 2-bit saturating counters.
        ifb.jmp_target = 32'h0000_0ABC;
        for (int i = 1; i <= 5; i++) begin
            jump_b(4'd10, lat);
            chk("b_taken_latency", 64'(lat), 64'(FC_B));
            chk("b_taken_sat", 64'(ifb.taken_cnt), 64'((i < 3) ? i : 3));
        end
        for (int i = 1; i <= 4; i++) begin
            jump_b(4'd13, lat);
            chk("b_nt_latency", 64'(lat), 64'(1));
            chk("b_nt_sat", 64'(ifb.not_taken_cnt), 64'((i < 3) ? i : 3));
        end

        // Reset while flushing: everything clears at once and the jump is never acked.
        ifb.jmp_req = 1'b1; ifb.jmp_op = 4'd10;
        repeat (2) @(negedge clk);
        chk("b_in_flush", 64'({ifb.flush, ifb.pc_load, ifb.jmp_ack}), 64'(3'b100));
        rst_b = 1'b0;
        #1;
        chk("b_rst_flush", 64'(ifb.flush), 64'(0));
        chk("b_rst_busy", 64'(ifb.busy), 64'(0));
        chk("b_rst_ack", 64'(ifb.jmp_ack), 64'(0));
        chk("b_rst_target", 64'(ifb.pc_target), 64'(0));
        chk("b_rst_taken_cnt", 64'(ifb.taken_cnt), 64'(0));
        chk("b_rst_nt_cnt", 64'(ifb.not_taken_cnt), 64'(0));
        ifb.jmp_req = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        acks = 0;
        repeat (5) begin
            @(negedge clk);
            if (ifb.jmp_ack || ifb.pc_load) acks++;
        end
        chk("b_no_ack_after_rst", 64'(acks), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
